// File: rtl/seqdet_ctrl.sv
// Serial 4-bit pattern detector over a window of win_len samples, with a done handshake.
// Overlapping matches are counted when SEQDET_OVERLAP_EN is defined; otherwise each match restarts the history.
module seqdet_ctrl #(
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       pat,
    input  logic [WIN_W-1:0] win_len,
    input  logic             x,
    output logic             busy,
    output logic             hit,
    output logic [WIN_W-1:0] hit_cnt,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [1:0]       status
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2,
        BAD    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       pat_q;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] bcnt;
    logic [WIN_W-1:0] bcnt_nxt;
    // Only the three most recent samples are stored; the oldest of the four
    // history bits would be shifted out before it could ever be compared.
    logic [2:0]       sh;
    logic [3:0]       sh_nxt;
    logic [2:0]       vcnt;
    logic [2:0]       vcnt_nxt;
    logic             match;
    logic             last;

    assign sh_nxt   = {sh, x};
    assign vcnt_nxt = (vcnt == 3'd4) ? 3'd4 : vcnt + 3'd1;
    assign bcnt_nxt = bcnt + 1'b1;
    assign match    = (vcnt_nxt == 3'd4) && (sh_nxt == pat_q);
    assign last     = (bcnt_nxt == len_q);

    assign busy       = (state == RUN) || (state == REPORT);
    assign done_valid = (state == REPORT);
    assign status     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (win_len == '0) ? REPORT : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= '0;
            len_q   <= '0;
            bcnt    <= '0;
            sh      <= '0;
            vcnt    <= '0;
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q   <= pat;
                        len_q   <= win_len;
                        bcnt    <= '0;
                        sh      <= '0;
                        vcnt    <= '0;
                        hit_cnt <= '0;
                    end
                end
                RUN: begin
                    bcnt <= bcnt_nxt;
                    if (match) begin
                        hit <= 1'b1;
                        if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
`ifdef SEQDET_OVERLAP_EN
                        sh   <= sh_nxt[2:0];
                        vcnt <= vcnt_nxt;
`else
                        sh   <= '0;
                        vcnt <= '0;
`endif
                    end else begin
                        sh   <= sh_nxt[2:0];
                        vcnt <= vcnt_nxt;
                    end
                end
                REPORT: begin
                end
                default: begin
                    // Unused encoding: fall back to reset values on the way to IDLE.
                    pat_q   <= '0;
                    len_q   <= '0;
                    bcnt    <= '0;
                    sh      <= '0;
                    vcnt    <= '0;
                    hit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Directed self-checking bench for seqdet_ctrl (default WIN_W instance plus a WIN_W=2 instance).
module tb_seqdet_ctrl;

`ifdef SEQDET_OVERLAP_EN
    localparam int E28_CNT  = 5;
    localparam int E28_MASK = 32'h0F8;
    localparam int E29_CNT  = 4;
    localparam int E29_MASK = 32'h2A8;
    localparam int E33_CNT  = 252;
    localparam int E32_CNT  = 2;
`else
    localparam int E28_CNT  = 2;
    localparam int E28_MASK = 32'h088;
    localparam int E29_CNT  = 2;
    localparam int E29_MASK = 32'h088;
    localparam int E33_CNT  = 63;
    localparam int E32_CNT  = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pat;
    logic [7:0] win_len;
    logic       x;
    logic       busy;
    logic       hit;
    logic [7:0] hit_cnt;
    logic       done_valid;
    logic       done_ready;
    logic [1:0] status;

    logic       start2;
    logic [1:0] win_len2;
    logic       busy2;
    logic       hit2;
    logic [1:0] hit_cnt2;
    logic       done_valid2;
    logic [1:0] status2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seqdet_ctrl #(.WIN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pat        (pat),
        .win_len    (win_len),
        .x          (x),
        .busy       (busy),
        .hit        (hit),
        .hit_cnt    (hit_cnt),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .status     (status)
    );

    seqdet_ctrl #(.WIN_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .pat        (pat),
        .win_len    (win_len2),
        .x          (x),
        .busy       (busy2),
        .hit        (hit2),
        .hit_cnt    (hit_cnt2),
        .done_valid (done_valid2),
        .done_ready (done_ready),
        .status     (status2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a window, scrambles pat/win_len after latching, feeds len samples
    // (bits[i] is sample i+1) and records hit after each sample in hmask[i].
    task automatic run_window(input logic [3:0] p, input logic [7:0] len,
                              input logic [255:0] bits, output logic [255:0] hmask);
        hmask   = '0;
        pat     = p;
        win_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        pat     = ~p;
        win_len = len + 8'd3;
        check("run_entry", {30'd0, status}, 32'd1);
        for (int i = 0; i < int'(len); i++) begin
            x = bits[i];
            tick();
            hmask[i] = hit;
        end
        x = 1'b0;
    endtask

    task automatic release_report();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    logic [255:0] mask;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        pat        = 4'h0;
        win_len    = 8'd0;
        x          = 1'b0;
        done_ready = 1'b0;
        start2     = 1'b0;
        win_len2   = 2'd0;
        #2;
        check("reset_outputs", {19'd0, busy, hit, hit_cnt, done_valid, status}, 32'd0);
        #10 rst = 1'b1;
        tick();
        check("idle_after_reset", {30'd0, status}, 32'd0);

        // Eight ones against 1111
        run_window(4'hF, 8'd8, {256{1'b1}}, mask);
        check("ones8_status", {30'd0, status}, 32'd2);
        check("ones8_done_valid", {31'd0, done_valid}, 32'd1);
        check("ones8_hit_cnt", {24'd0, hit_cnt}, E28_CNT);
        check("ones8_hit_mask", mask[31:0], E28_MASK);
        release_report();
        check("ones8_back_idle", {30'd0, status}, 32'd0);
        check("idle_keeps_hit_cnt", {24'd0, hit_cnt}, E28_CNT);

        // Alternating 1010 over ten samples
        run_window(4'hA, 8'd10, {246'd0, 10'b0101010101}, mask);
        check("alt10_status", {30'd0, status}, 32'd2);
        check("alt10_hit_cnt", {24'd0, hit_cnt}, E29_CNT);
        check("alt10_hit_mask", mask[31:0], E29_MASK);

        // REPORT holds against start while done_ready stays low
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            tick();
            check("hold_done_valid", {31'd0, done_valid}, 32'd1);
            check("hold_hit_cnt", {24'd0, hit_cnt}, E29_CNT);
        end
        start      = 1'b1;
        done_ready = 1'b1;
        tick();
        check("release_status", {30'd0, status}, 32'd0);
        start      = 1'b0;
        done_ready = 1'b0;
        tick();
        check("start_not_carried", {30'd0, status}, 32'd0);

        // Zero-length window goes straight to REPORT
        pat     = 4'h5;
        win_len = 8'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("zero_len_status", {30'd0, status}, 32'd2);
        check("zero_len_done_valid", {31'd0, done_valid}, 32'd1);
        check("zero_len_hit_cnt", {24'd0, hit_cnt}, 32'd0);
        release_report();

        // Longest window
        run_window(4'hF, 8'd255, {256{1'b1}}, mask);
        check("ones255_status", {30'd0, status}, 32'd2);
        check("ones255_hit_cnt", {24'd0, hit_cnt}, E33_CNT);
        release_report();

        // Asynchronous reset in the middle of a window
        pat     = 4'hF;
        win_len = 8'd10;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        x       = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        check("pre_reset_hit_cnt", {24'd0, hit_cnt}, E32_CNT);
        #3 rst = 1'b0;
        #1;
        check("mid_run_reset", {19'd0, busy, hit, hit_cnt, done_valid, status}, 32'd0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_idle", {29'd0, done_valid, status}, 32'd0);
        end
        x = 1'b0;

        // Narrow counter: three samples can never complete a 4-bit pattern
        pat      = 4'hF;
        win_len2 = 2'd3;
        start2   = 1'b1;
        tick();
        start2   = 1'b0;
        x        = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        x = 1'b0;
        check("w2_status", {30'd0, status2}, 32'd2);
        check("w2_hit_cnt", {30'd0, hit_cnt2}, 32'd0);
        release_report();
        check("w2_back_idle", {30'd0, status2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seqdet_ctrl.md
SEQDET_CTRL -- requirements
Module: seqdet_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_W, default 8, the width of win_len and hit_cnt.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a detection window (used only in IDLE).
REQ-005 The block SHALL have port pat, input, 4 bits, the target pattern; pat[3] is the first (oldest) serial bit.
REQ-006 The block SHALL have port win_len, input, WIN_W bits, the number of serial bits to sample in the window.
REQ-007 The block SHALL have port x, input, 1 bit, the serial data, sampled once per clk in RUN.
REQ-008 The block SHALL have port busy, output, 1 bit, high in RUN and REPORT.
REQ-009 The block SHALL have port hit, output, 1 bit, a registered one-cycle pulse per detected pattern.
REQ-010 The block SHALL have port hit_cnt, output, WIN_W bits, the number of matches in the current or last window.
REQ-011 The block SHALL have port done_valid, output, 1 bit, result-available handshake (high in REPORT).
REQ-012 The block SHALL have port done_ready, input, 1 bit, the consumer's acceptance of the result.
REQ-013 The block SHALL have port status, output, 2 bits, the FSM state (IDLE=0, RUN=1, REPORT=2).

Function
REQ-014 In IDLE, start=1 SHALL latch pat and win_len internally, clear hit_cnt, the 4-bit history sh, the valid-bit count vcnt (0..4) and the bit counter, and go to RUN; if win_len=0 it SHALL go to REPORT instead.
REQ-015 In RUN, each cycle SHALL sample x, shift it into sh (shifting left, x entering at the LSB), increment vcnt (saturating at 4) and increment the bit counter.
REQ-016 A match SHALL occur when vcnt (counting the current sample) equals 4 and {sh[2:0],x} equals the latched pat.
REQ-017 On a match, hit SHALL pulse high for the next cycle only, and hit_cnt SHALL increment, saturating at 2^WIN_W-1.
REQ-018 When the sample numbered win_len has been taken, the FSM SHALL go to REPORT on that edge; the window is exactly win_len samples.
REQ-019 In REPORT, done_valid SHALL be 1 and hit_cnt SHALL be held stable; done_ready=1 SHALL return the FSM to IDLE on that edge.
REQ-020 start SHALL be ignored in RUN and REPORT, and in a simultaneous start/done_ready in REPORT; start must be reasserted in IDLE.
REQ-021 Changes on pat or win_len after latching SHALL NOT affect the active window.
REQ-022 Status encoding 3 SHALL return to IDLE on the next edge with outputs in their reset values.
REQ-023 hit_cnt SHALL retain its last value in IDLE until the next start.

Reset
REQ-024 rst=0 SHALL immediately, regardless of clk, force status=0, busy=0, hit=0, hit_cnt=0, done_valid=0, and clear sh, vcnt and the bit counter.
REQ-025 Reset asserted mid-RUN or mid-REPORT SHALL abort the window with no done_valid; after release the block SHALL wait in IDLE for start.

Configuration
REQ-026 Macro SEQDET_OVERLAP_EN defined: after a match, sh and vcnt SHALL be retained, so overlapping matches count.
REQ-027 Macro SEQDET_OVERLAP_EN undefined: after a match, sh and vcnt SHALL be cleared to 0, so the next match needs 4 fresh samples.

Verification
REQ-028 pat=1111, win_len=8, x=1 for 8 samples -> hit_cnt=5 with SEQDET_OVERLAP_EN, 2 without; done_valid is high the cycle after the 8th sample.
REQ-029 pat=1010, win_len=10, x=1,0,1,0,1,0,1,0,1,0 -> hit_cnt=4 with SEQDET_OVERLAP_EN, 2 without; each hit pulse is one cycle wide.
REQ-030 start with win_len=0 -> status goes 0->2 in one cycle, done_valid=1, hit_cnt=0.
REQ-031 done_ready held low for 5 cycles in REPORT while start pulses -> done_valid stays 1, hit_cnt stays unchanged, no new window; done_ready=1 -> status=0 next cycle.
REQ-032 rst pulsed low mid-RUN (between edges) -> all outputs are 0 immediately; after release the FSM stays in IDLE until start.
REQ-033 pat=1111, win_len=255, x=1 throughout, SEQDET_OVERLAP_EN defined -> hit_cnt=252; with WIN_W=2, pat=1111, win_len=3, no match is possible -> hit_cnt=0.
